// File: rtl/fpu_share_arbiter_if.sv
// Bundle of requester-side and FPU-side signals of the shared FPU arbiter.
//
// Handshake semantics (both sides):
//   Request side : a requester raises req_i[r] with a stable payload
//                  (operands_i/op_i/flags_i slice r) and holds both until it
//                  sees gnt_o[r]=1 in the same cycle; the transfer happens in
//                  that cycle. Result side: rvalid_o[r] is a single-cycle
//                  pulse, no backpressure; rdata_o/rflags_o are valid with it.
//   FPU side     : apu_req_o with payload is offered; the transfer happens in
//                  the cycle apu_gnt_i=1. apu_rvalid_i pulses once per
//                  accepted op, in acceptance order, never stalled.
interface fpu_share_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5,
  parameter int DEPTH    = 4
);
  // requester side
  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ-1:0]          gnt_o;
  logic [NUM_REQ*NARGS*32-1:0] operands_i;
  logic [NUM_REQ*WOP-1:0]      op_i;
  logic [NUM_REQ*NDSFLAGS-1:0] flags_i;
  logic [NUM_REQ-1:0]          rvalid_o;
  logic [31:0]                 rdata_o;
  logic [NUSFLAGS-1:0]         rflags_o;
  // FPU side
  logic                        apu_req_o;
  logic                        apu_gnt_i;
  logic [NARGS*32-1:0]         apu_operands_o;
  logic [WOP-1:0]              apu_op_o;
  logic [NDSFLAGS-1:0]         apu_flags_o;
  logic                        apu_rvalid_i;
  logic [31:0]                 apu_result_i;
  logic [NUSFLAGS-1:0]         apu_flags_i;
  // status
  logic [$clog2(DEPTH):0]      outstanding_o;
  logic                        err_o;

  // arbiter side
  modport slave (
    input  req_i, operands_i, op_i, flags_i,
           apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    output gnt_o, rvalid_o, rdata_o, rflags_o,
           apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
           outstanding_o, err_o
  );

  // requesters + FPU side (environment)
  modport master (
    output req_i, operands_i, op_i, flags_i,
           apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    input  gnt_o, rvalid_o, rdata_o, rflags_o,
           apu_req_o, apu_operands_o, apu_op_o, apu_flags_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// Shares one pipelined, in-order FPU between NUM_REQ requesters.
// Round-robin selection with a request lock (a refused request keeps the
// FPU input until granted), and an ID FIFO that steers each returning FPU
// result to the requester that issued it.
module fpu_share_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5,
  parameter int DEPTH    = 4
) (
  input logic clk_i,
  input logic rst_i,
  fpu_share_arbiter_if.slave bus
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int OPW  = NARGS * 32;
  localparam logic [IDXW:0] NR = (IDXW+1)'(NUM_REQ);

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] lock_idx;
  logic            lock_vld;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] id_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            err_q;
  logic            full;
  logic            empty;
  logic            can_issue;
  logic            issue;
  logic            push;
  logic            pop;
  logic [IDXW-1:0] head_id;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // a result returning this cycle frees a FIFO slot for a new issue
  assign can_issue = !full | bus.apu_rvalid_i;
  // reset masks the combinational request path so outputs read zero in reset
  assign issue     = !rst_i & (|bus.req_i) & can_issue;
  assign push      = issue & bus.apu_gnt_i;
  assign pop       = bus.apu_rvalid_i & !empty;
  assign head_id   = id_mem[rd_ptr];

  // pick the locked requester if still requesting, else round-robin from rr_ptr
  always_comb begin
    logic [IDXW:0] cand;
    logic          found;
    sel   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    if (lock_vld && bus.req_i[lock_idx]) begin
      sel = lock_idx;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_ptr} + (IDXW+1)'(i);
        if (cand >= NR) cand = cand - NR;
        if (!found && bus.req_i[cand[IDXW-1:0]]) begin
          sel   = cand[IDXW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // route the selected payload to the FPU; zero payload when not requesting
  always_comb begin
    bus.apu_operands_o = '0;
    bus.apu_op_o       = '0;
    bus.apu_flags_o    = '0;
    if (issue) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (sel == IDXW'(r)) begin
          bus.apu_operands_o = bus.operands_i[r*OPW +: OPW];
          bus.apu_op_o       = bus.op_i[r*WOP +: WOP];
          bus.apu_flags_o    = bus.flags_i[r*NDSFLAGS +: NDSFLAGS];
        end
      end
    end
  end

  // one-hot grant to the selected requester, one-hot result to the FIFO head
  always_comb begin
    bus.gnt_o    = '0;
    bus.rvalid_o = '0;
    if (push) bus.gnt_o[sel] = 1'b1;
    if (pop)  bus.rvalid_o[head_id] = 1'b1;
  end

  assign bus.apu_req_o     = issue;
  assign bus.rdata_o       = bus.apu_result_i;
  assign bus.rflags_o      = bus.apu_flags_i;
  assign bus.outstanding_o = count;
  assign bus.err_o         = err_q;

  // round-robin pointer advances past the winner; lock holds a refused request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock_idx <= '0;
      lock_vld <= 1'b0;
    end else if (push) begin
      rr_ptr   <= (sel == IDXW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
      lock_vld <= 1'b0;
    end else if (issue) begin
      lock_idx <= sel;
      lock_vld <= 1'b1;
    end else if (lock_vld && !bus.req_i[lock_idx]) begin
      lock_vld <= 1'b0;
    end
  end

  // ID storage; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

  // FIFO pointers, occupancy and sticky error for results with nothing in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (bus.apu_rvalid_i && empty) err_q <= 1'b1;
    end
  end
endmodule
